multdiv_ctrl: RTL

Sequencing controller between the execute stage and the shared multiplier/divider units. Accepts one mult or div request at a time, latches and holds the operands stable for the whole iteration, issues the single-cycle start strobe, and stalls the pipeline until the selected unit reports ready. It then presents exactly one writeback: the result to `rd`, or on exception the status code to `$r30`. Sits beside the ALU in execute; drives `ctrl_MULT`/`ctrl_DIV` and reads back result/exception/ready.

---
 rtl/multdiv_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the shared multiplier/divider: latches one op,
// strobes the selected unit, stalls until ready or timeout, then emits one writeback.
module multdiv_ctrl #(
    parameter int TIMEOUT  = 40,
    parameter int MUL_CODE = 4,
    parameter int DIV_CODE = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_is_div,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] mult_result,
    input  logic        mult_exception,
    input  logic        mult_resultRDY,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    input  logic        div_resultRDY,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exc
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [4:0]     rd_q, rd_d;
    logic           is_div_q, is_div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ctrl_mult_q, ctrl_mult_d, ctrl_div_q, ctrl_div_d;
    logic           wb_valid_q, wb_valid_d, wb_exc_q, wb_exc_d;
    logic [4:0]     wb_rd_q, wb_rd_d;
    logic [31:0]    wb_data_q, wb_data_d;

    logic           sel_rdy, sel_exc, timed_out;
    logic [31:0]    sel_res, exc_code;

    assign sel_rdy   = is_div_q ? div_resultRDY  : mult_resultRDY;
    assign sel_exc   = is_div_q ? div_exception  : mult_exception;
    assign sel_res   = is_div_q ? div_result     : mult_result;
    assign exc_code  = is_div_q ? 32'(DIV_CODE)  : 32'(MUL_CODE);
    // Counter holds the number of RUN cycles already completed, so the last
    // permitted RUN cycle is the one where it reads TIMEOUT-1.
    assign timed_out = (cnt_q >= CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        is_div_d    = is_div_q;
        cnt_d       = cnt_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = '0;
        wb_data_d   = '0;
        wb_exc_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    a_d         = req_a;
                    b_d         = req_b;
                    rd_d        = req_rd;
                    is_div_d    = req_is_div;
                    ctrl_mult_d = !req_is_div;
                    ctrl_div_d  = req_is_div;
                    state_d     = START;
                end
            end
            START: begin
                // RDY is deliberately not looked at here; it may be stale.
                cnt_d   = '0;
                state_d = flush ? IDLE : RUN;
            end
            RUN: begin
                cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
                if (flush) begin
                    state_d = IDLE;
                end else if (sel_rdy || timed_out) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    if (sel_rdy && !sel_exc) begin
                        wb_rd_d   = rd_q;
                        wb_data_d = sel_res;
                    end else begin
                        wb_rd_d   = 5'd30;
                        wb_data_d = exc_code;
                        wb_exc_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            is_div_q    <= 1'b0;
            cnt_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            is_div_q    <= is_div_d;
            cnt_q       <= cnt_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign unit_a    = a_q;
    assign unit_b    = b_q;
    assign ctrl_MULT = ctrl_mult_q;
    assign ctrl_DIV  = ctrl_div_q;
    // A flush arriving during DONE must still kill the writeback.
    assign wb_valid  = wb_valid_q & ~flush;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_exc    = wb_exc_q;
    assign stall     = ((state_q == IDLE) && req_valid && !flush) ||
                       (state_q == START) || (state_q == RUN);
endmodule
